// File: rtl/toy_lsu_issue_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : toy_lsu_issue_buf                                          |
// | Description : LSU issue buffer. Random-access dispatch writes, in-order  |
// |               multi-lane issue gated by store/load credits.              |
// |               Optional operand forwarding: TOY_LSU_BUF_FORWARD_EN        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module toy_lsu_issue_buf #(
    parameter int S_CH      = 4,
    parameter int M_CH      = 4,
    parameter int DEPTH     = 16,
    parameter int PLD_W     = 64,
    parameter int OPND_W    = 32,
    parameter int ST_CREDIT = 8,
    parameter int LD_CREDIT = 8,
    parameter int FWD_N     = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [S_CH-1:0]                    s_vld,
    input  logic [S_CH*$clog2(DEPTH)-1:0]      s_id,
    input  logic [S_CH-1:0]                    s_is_st,
    input  logic [S_CH*PLD_W-1:0]              s_pld,
    input  logic [S_CH-1:0]                    s_fwd_en,
    input  logic [S_CH*$clog2(FWD_N)-1:0]      s_fwd_id,
    input  logic [FWD_N*OPND_W-1:0]            fwd_data,
    output logic [M_CH-1:0]                    m_vld,
    input  logic [M_CH-1:0]                    m_rdy,
    output logic [M_CH-1:0]                    m_is_st,
    output logic [M_CH*PLD_W-1:0]              m_pld,
    output logic [$clog2(DEPTH):0]             rd_ptr,
    output logic [$clog2(DEPTH):0]             occupancy,
    input  logic                               st_credit_en,
    input  logic [3:0]                         st_credit_num,
    input  logic                               ld_credit_en,
    input  logic [3:0]                         ld_credit_num,
    input  logic                               cancel_en
);

    localparam int c_PW   = $clog2(DEPTH);
    localparam int c_FW   = $clog2(FWD_N);
    localparam int c_CMAX = (ST_CREDIT > LD_CREDIT) ? ST_CREDIT : LD_CREDIT;
    localparam int c_CW   = $clog2(c_CMAX) + 1;
    localparam int c_AW   = $clog2(M_CH + 1);

    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_is_st;
    logic [PLD_W-1:0]  r_pld [DEPTH];
    logic [c_PW:0]     r_rd_ptr;
    logic [c_PW:0]     r_occ;
    logic [c_CW-1:0]   r_st_credit;
    logic [c_CW-1:0]   r_ld_credit;

    logic [DEPTH-1:0]  w_wr_en;
    logic [DEPTH-1:0]  w_wr_st;
    logic [PLD_W-1:0]  w_wr_pld [DEPTH];
    logic [c_PW-1:0]   w_idx [M_CH];
    logic [DEPTH-1:0]  w_clr;
    logic [c_AW-1:0]   w_acc_cnt;
    logic [c_AW-1:0]   w_acc_st;
    logic [c_AW-1:0]   w_acc_ld;
    logic              w_acc_run;
    logic              w_all_vld;
    int unsigned       w_st_need;
    int unsigned       w_ld_need;
    logic [c_PW:0]     w_new_cnt;

`ifdef TOY_LSU_BUF_FORWARD_EN
    logic [DEPTH-1:0]  r_fwd_pend;
    logic [c_FW-1:0]   r_fwd_sel [DEPTH];
    logic [DEPTH-1:0]  w_wr_fwd;
    logic [c_FW-1:0]   w_wr_fsel [DEPTH];
`else
    logic              w_unused_fwd;
    assign w_unused_fwd = ^{s_fwd_en, s_fwd_id, fwd_data};
`endif

    // Later channels overwrite earlier ones, so the highest index wins on an id clash.
    always_comb begin
        w_wr_en = '0;
        w_wr_st = '0;
        for (int e = 0; e < DEPTH; e++) begin
            w_wr_pld[e] = '0;
        end
`ifdef TOY_LSU_BUF_FORWARD_EN
        w_wr_fwd = '0;
        for (int e = 0; e < DEPTH; e++) begin
            w_wr_fsel[e] = '0;
        end
`endif
        for (int c = 0; c < S_CH; c++) begin
            if (s_vld[c]) begin
                w_wr_en[s_id[c*c_PW +: c_PW]]  = 1'b1;
                w_wr_st[s_id[c*c_PW +: c_PW]]  = s_is_st[c];
                w_wr_pld[s_id[c*c_PW +: c_PW]] = s_pld[c*PLD_W +: PLD_W];
`ifdef TOY_LSU_BUF_FORWARD_EN
                w_wr_fwd[s_id[c*c_PW +: c_PW]]  = s_fwd_en[c];
                w_wr_fsel[s_id[c*c_PW +: c_PW]] = s_fwd_id[c*c_FW +: c_FW];
`endif
            end
        end
    end

    for (genvar k = 0; k < M_CH; k++) begin : g_lane
        logic [PLD_W-1:0] w_pld;
        assign w_idx[k]   = r_rd_ptr[c_PW-1:0] + c_PW'(k);
        assign m_is_st[k] = r_is_st[w_idx[k]];
`ifdef TOY_LSU_BUF_FORWARD_EN
        always_comb begin
            w_pld = r_pld[w_idx[k]];
            if (r_fwd_pend[w_idx[k]]) begin
                w_pld[OPND_W-1:0] = fwd_data[r_fwd_sel[w_idx[k]]*OPND_W +: OPND_W];
            end
        end
`else
        assign w_pld = r_pld[w_idx[k]];
`endif
        assign m_pld[k*PLD_W +: PLD_W] = w_pld;
    end

    // Lane k needs the whole run from rd_ptr to be valid and the cumulative credit demand to fit.
    always_comb begin
        w_all_vld = 1'b1;
        w_st_need = 0;
        w_ld_need = 0;
        m_vld     = '0;
        for (int k = 0; k < M_CH; k++) begin
            w_all_vld = w_all_vld & r_valid[w_idx[k]];
            if (r_is_st[w_idx[k]]) begin
                w_st_need = w_st_need + 1;
            end else begin
                w_ld_need = w_ld_need + 1;
            end
            m_vld[k] = w_all_vld && (w_st_need <= 32'(r_st_credit))
                                 && (w_ld_need <= 32'(r_ld_credit));
        end
    end

    always_comb begin
        w_acc_run = 1'b1;
        w_acc_cnt = '0;
        w_acc_st  = '0;
        w_acc_ld  = '0;
        w_clr     = '0;
        for (int k = 0; k < M_CH; k++) begin
            w_acc_run = w_acc_run & m_vld[k] & m_rdy[k];
            if (w_acc_run) begin
                w_acc_cnt = w_acc_cnt + c_AW'(1);
                if (r_is_st[w_idx[k]]) begin
                    w_acc_st = w_acc_st + c_AW'(1);
                end else begin
                    w_acc_ld = w_acc_ld + c_AW'(1);
                end
                w_clr[w_idx[k]] = 1'b1;
            end
        end
    end

    always_comb begin
        w_new_cnt = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (w_wr_en[e] && !r_valid[e]) begin
                w_new_cnt = w_new_cnt + (c_PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
            r_st_credit <= c_CW'(ST_CREDIT);
            r_ld_credit <= c_CW'(LD_CREDIT);
        end else if (cancel_en) begin
            r_valid     <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
            r_st_credit <= c_CW'(ST_CREDIT);
            r_ld_credit <= c_CW'(LD_CREDIT);
        end else begin
            // A write beats a same-cycle issue clear of the same entry.
            r_valid     <= (r_valid & ~w_clr) | w_wr_en;
            r_rd_ptr    <= r_rd_ptr + (c_PW+1)'(w_acc_cnt);
            r_occ       <= r_occ + w_new_cnt - (c_PW+1)'(w_acc_cnt);
            r_st_credit <= r_st_credit + (st_credit_en ? c_CW'(st_credit_num) : c_CW'(0))
                           - c_CW'(w_acc_st);
            r_ld_credit <= r_ld_credit + (ld_credit_en ? c_CW'(ld_credit_num) : c_CW'(0))
                           - c_CW'(w_acc_ld);
        end
    end

`ifdef TOY_LSU_BUF_FORWARD_EN
    // Pending lasts exactly one cycle: the forward bus is sampled the cycle after the write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fwd_pend <= '0;
        end else if (cancel_en) begin
            r_fwd_pend <= '0;
        end else begin
            r_fwd_pend <= w_wr_fwd;
        end
    end
`endif

    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (w_wr_en[e]) begin
                r_pld[e]   <= w_wr_pld[e];
                r_is_st[e] <= w_wr_st[e];
`ifdef TOY_LSU_BUF_FORWARD_EN
                r_fwd_sel[e] <= w_wr_fsel[e];
            end else if (r_fwd_pend[e]) begin
                r_pld[e][OPND_W-1:0] <= fwd_data[r_fwd_sel[e]*OPND_W +: OPND_W];
`endif
            end
        end
    end

    assign rd_ptr    = r_rd_ptr;
    assign occupancy = r_occ;

endmodule
`default_nettype wire
